// File: rtl/sys_timer_csr_reader_if.sv
// Request/response and timer-select signals between the CSR stage, the reader and the system-timer unit.
// The reader is the slave side of this bundle; the environment (CSR stage plus timer unit) is the master.
interface sys_timer_csr_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic        req_snap64;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic [1:0]  tmr_sel;
  logic        tmr_upper;
  logic [31:0] tmr_data;

  modport slave (
    input  req_valid, req_addr, req_snap64, rsp_ready, tmr_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, tmr_sel, tmr_upper
  );

  modport master (
    output req_valid, req_addr, req_snap64, rsp_ready, tmr_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, tmr_sel, tmr_upper
  );
endinterface

// File: rtl/sys_timer_csr_reader.sv
// Counter-CSR read initiator: single 32-bit reads or hi-lo-hi consistent 64-bit snapshots
// with bounded retry, returning the captured word on a valid/ready response channel.
module sys_timer_csr_reader #(
  parameter int MAX_RETRY = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sys_timer_csr_reader_if.slave       bus
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  localparam logic [1:0] SEL_CYCLE = 2'd0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC32 = 3'd1,
    S_HI1   = 3'd2,
    S_LO    = 3'd3,
    S_HI2   = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [1:0]      r_sel;
  logic            r_upper;
  logic [31:0]     r_hi1;
  logic [31:0]     r_lo;
  logic [RW-1:0]   r_retry;
  logic [63:0]     r_rsp_data;
  logic            r_rsp_err;

  logic            w_legal;
  logic            w_hi_match;
  logic            w_retry_left;

  // Counter CSRs live at 0xC00..0xC02 (lower) and 0xC80..0xC82 (upper); bit 7 picks the half.
  assign w_legal      = (bus.req_addr[11:8] == 4'hC) && (bus.req_addr[6:2] == 5'd0) &&
                        (bus.req_addr[1:0] != 2'd3);
  assign w_hi_match   = (bus.tmr_data == r_hi1);
  assign w_retry_left = (r_retry < RETRY_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (!w_legal) begin
            w_state_next = S_RESP;
          end else if (bus.req_snap64) begin
            w_state_next = S_HI1;
          end else begin
            w_state_next = S_ACC32;
          end
        end
      end
      S_ACC32: w_state_next = S_RESP;
      S_HI1:   w_state_next = S_LO;
      S_LO:    w_state_next = S_HI2;
      S_HI2: begin
        if (w_hi_match || !w_retry_left) begin
          w_state_next = S_RESP;
        end else begin
          w_state_next = S_HI1;
        end
      end
      // Leaving RESP always passes through IDLE, so back-to-back requests see one bubble.
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (r_state == S_IDLE);
    bus.rsp_valid = (r_state == S_RESP);
    bus.tmr_sel   = SEL_CYCLE;
    bus.tmr_upper = 1'b0;
    case (r_state)
      S_ACC32: begin
        bus.tmr_sel   = r_sel;
        bus.tmr_upper = r_upper;
      end
      S_HI1, S_HI2: begin
        bus.tmr_sel   = r_sel;
        bus.tmr_upper = 1'b1;
      end
      S_LO: begin
        bus.tmr_sel   = r_sel;
        bus.tmr_upper = 1'b0;
      end
      default: begin
        bus.tmr_sel   = SEL_CYCLE;
        bus.tmr_upper = 1'b0;
      end
    endcase
  end

  assign bus.rsp_data = r_rsp_data;
  assign bus.rsp_err  = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel      <= SEL_CYCLE;
      r_upper    <= 1'b0;
      r_hi1      <= '0;
      r_lo       <= '0;
      r_retry    <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_sel      <= bus.req_addr[1:0];
            r_upper    <= bus.req_addr[7];
            r_retry    <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= !w_legal;
          end
        end
        S_ACC32: r_rsp_data <= {32'h0, bus.tmr_data};
        S_HI1:   r_hi1      <= bus.tmr_data;
        S_LO:    r_lo       <= bus.tmr_data;
        S_HI2: begin
          if (w_hi_match) begin
            r_rsp_data <= {r_hi1, r_lo};
          end else if (!w_retry_left) begin
            // Out of retries: report the latest high half alongside the last low half.
            r_rsp_data <= {bus.tmr_data, r_lo};
            r_rsp_err  <= 1'b1;
          end else begin
            r_retry <= r_retry + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_timer_csr_reader.sv
// Randomized scoreboard bench for sys_timer_csr_reader: a linear-counter timer responder, a
// spec-level read model feeding an expectation queue, and an independent response monitor.
module tb_sys_timer_csr_reader;

  localparam int MAXR = 1;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
    logic [63:0] c0;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [63:0] cyc;
  logic [63:0] t0;
  logic [63:0] tbase [3];
  logic [63:0] tinc  [3];
  logic [63:0] tval;
  exp_t        sbq[$];
  int          n_tests;
  int          n_fail;
  int          n_rsp;

  sys_timer_csr_reader_if bus();

  sys_timer_csr_reader #(.MAX_RETRY(MAXR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 64'd1;

  // Timer unit: each counter advances by tinc per cycle from tbase, starting at cycle t0.
  always_comb begin
    tval = 64'h0;
    if (bus.tmr_sel != 2'd3) begin
      tval = tbase[bus.tmr_sel] + (cyc - t0) * tinc[bus.tmr_sel];
    end
    bus.tmr_data = bus.tmr_upper ? tval[63:32] : tval[31:0];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Read outcome from the rules: value seen k cycles after the accept cycle is b + k*inc.
  function automatic exp_t model(input logic [11:0] a, input logic s,
                                 input logic [63:0] b, input logic [63:0] inc);
    exp_t        e;
    logic [11:0] am;
    logic [63:0] v1, v2, v3;
    bit          done;
    am     = a & 12'hF7F;
    e.c0   = '0;
    e.data = '0;
    e.err  = 1'b1;
    e.lat  = 1;
    done   = 1'b0;
    if (am == 12'hC00 || am == 12'hC01 || am == 12'hC02) begin
      if (!s) begin
        v1     = b + inc;
        e.data = {32'h0, a[7] ? v1[63:32] : v1[31:0]};
        e.err  = 1'b0;
        e.lat  = 2;
      end else begin
        for (int j = 0; j <= MAXR; j++) begin
          if (!done) begin
            v1    = b + 64'(1 + 3 * j) * inc;
            v2    = b + 64'(2 + 3 * j) * inc;
            v3    = b + 64'(3 + 3 * j) * inc;
            e.lat = 4 + 3 * j;
            if (v1[63:32] == v3[63:32]) begin
              e.data = {v1[63:32], v2[31:0]};
              e.err  = 1'b0;
              done   = 1'b1;
            end else if (j == MAXR) begin
              e.data = {v3[63:32], v2[31:0]};
              e.err  = 1'b1;
              done   = 1'b1;
            end
          end
        end
      end
    end
    return e;
  endfunction

  // Called at a negedge; holds req_valid until the reader is idle, then programs the timer.
  task automatic do_req(input logic [11:0] a, input logic s, input logic [63:0] b,
                        input logic [63:0] inc, input bit track);
    int   n;
    exp_t e;
    n = 0;
    bus.req_addr   = a;
    bus.req_snap64 = s;
    bus.req_valid  = 1'b1;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_accept: req_ready=%0b after %0d cycles, expected 1", bus.req_ready, n);
      bus.req_valid = 1'b0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (i == int'(a[1:0])) begin
        tbase[i] = b;
        tinc[i]  = inc;
      end else begin
        tbase[i] = b ^ 64'h0F0F_0F0F_F0F0_F0F0 ^ 64'(i);
        tinc[i]  = inc + 64'd1;
      end
    end
    t0 = cyc;
    if (track) begin
      e    = model(a, s, b, inc);
      e.c0 = cyc;
      sbq.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || bus.rsp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sbq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: pops one expectation per presented response and checks hold-stability under stall.
  initial begin
    bit          have;
    logic [63:0] hd;
    logic        he;
    int          stall;
    int          wait_n;
    exp_t        e;
    have          = 1'b0;
    hd            = '0;
    he            = 1'b0;
    stall         = 0;
    wait_n        = 0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have   = 1'b0;
        wait_n = 0;
      end else if (bus.rsp_valid) begin
        wait_n = 0;
        chk("req_ready_in_resp", {63'h0, bus.req_ready}, 64'h0);
        if (!have) begin
          if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: rsp_valid=1 data=0x%0h, expected no response", bus.rsp_data);
          end else begin
            e = sbq.pop_front();
            n_rsp++;
            $display("[TB] rsp %0d data=0x%016h err=%0b lat=%0d", n_rsp, bus.rsp_data, bus.rsp_err,
                     int'(cyc - e.c0));
            chk("rsp_data", bus.rsp_data, e.data);
            chk("rsp_err", {63'h0, bus.rsp_err}, {63'h0, e.err});
            chk("rsp_latency", cyc - e.c0, 64'(e.lat));
          end
          have  = 1'b1;
          hd    = bus.rsp_data;
          he    = bus.rsp_err;
          stall = ($urandom_range(0, 3) == 0) ? 5 : $urandom_range(0, 2);
        end else begin
          chk("rsp_data_hold", bus.rsp_data, hd);
          chk("rsp_err_hold", {63'h0, bus.rsp_err}, {63'h0, he});
        end
        if (stall > 0) begin
          bus.rsp_ready = 1'b0;
          stall--;
        end else begin
          bus.rsp_ready = 1'b1;
          have          = 1'b0;
        end
      end else begin
        bus.rsp_ready = 1'($urandom_range(0, 1));
        if (sbq.size() != 0) begin
          wait_n++;
          if (wait_n > 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=0 for %0d cycles, expected a response", wait_n);
            e      = sbq.pop_front();
            wait_n = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] legal_addr [6];
    logic [11:0] a;
    logic [63:0] b;
    logic [63:0] inc;
    int          r;
    n_tests        = 0;
    n_fail         = 0;
    n_rsp          = 0;
    t0             = '0;
    for (int i = 0; i < 3; i++) begin
      tbase[i] = '0;
      tinc[i]  = '0;
    end
    legal_addr     = '{12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82};
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_snap64 = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", {63'h0, bus.req_ready}, 64'h1);
    chk("reset_rsp_valid", {63'h0, bus.rsp_valid}, 64'h0);
    chk("reset_rsp_data", bus.rsp_data, 64'h0);
    chk("reset_rsp_err", {63'h0, bus.rsp_err}, 64'h0);
    chk("reset_tmr_sel", {62'h0, bus.tmr_sel}, 64'h0);
    chk("reset_tmr_upper", {63'h0, bus.tmr_upper}, 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases from the read rules.
    do_req(12'hC00, 1'b0, 64'h0000_00AB_1234_5678, 64'h0, 1'b1);
    do_req(12'hC01, 1'b1, 64'h0000_0007_FFFF_FFF0, 64'h0, 1'b1);
    do_req(12'hC80, 1'b1, 64'h0000_0007_FFFF_FFFE, 64'h1, 1'b1);
    do_req(12'hC00, 1'b1, 64'h0000_0007_0000_0000, 64'h1_0000_0000, 1'b1);
    do_req(12'hC03, 1'b0, 64'h1111_2222_3333_4444, 64'h0, 1'b1);
    do_req(12'hC82, 1'b0, 64'hCAFE_F00D_0BAD_BEEF, 64'h3, 1'b1);
    do_req(12'hC81, 1'b1, 64'h0000_0002_FFFF_FFFF, 64'h1, 1'b1);
    do_req(12'hD00, 1'b1, 64'h5555_5555_5555_5555, 64'h0, 1'b1);
    drain();

    // Reset asserted while the reader is in its LO access of a snapshot.
    do_req(12'hC81, 1'b1, 64'h0000_0009_0000_0010, 64'h1, 1'b0);
    @(negedge clk);
    chk("lo_tmr_sel", {62'h0, bus.tmr_sel}, 64'h1);
    chk("lo_tmr_upper", {63'h0, bus.tmr_upper}, 64'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", {63'h0, bus.req_ready}, 64'h1);
    chk("midrst_rsp_valid", {63'h0, bus.rsp_valid}, 64'h0);
    chk("midrst_rsp_data", bus.rsp_data, 64'h0);
    chk("midrst_rsp_err", {63'h0, bus.rsp_err}, 64'h0);
    chk("midrst_tmr_sel", {62'h0, bus.tmr_sel}, 64'h0);
    chk("midrst_tmr_upper", {63'h0, bus.tmr_upper}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_req_ready", {63'h0, bus.req_ready}, 64'h1);

    // Randomized traffic against the model.
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       a = legal_addr[r];
      else if (r == 6) a = 12'hC03;
      else if (r == 7) a = 12'hC83;
      else             a = 12'($urandom);
      b = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) b[31:0] = 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
      case ($urandom_range(0, 4))
        0:       inc = 64'h0;
        1:       inc = 64'h1;
        2:       inc = 64'($urandom_range(2, 5));
        3:       inc = 64'h1_0000_0000;
        default: inc = {32'h0, $urandom};
      endcase
      do_req(a, 1'($urandom_range(0, 1)), b, inc, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
